multi_channel_moving_mean: RTL and testbench

//  Streaming moving-average filter over the last 2**LOG2_WIN samples, kept per channel for
//  up to NUM_CH time-multiplexed channels of signed samples. It is the parametrised

---
 rtl/mean_pkg.sv | 11 +
 rtl/mean_sample_ram.sv | 18 +
 rtl/multi_channel_moving_mean.sv | 101 ++++++++++
 tb/tb_multi_channel_moving_mean.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/mean_pkg.sv
// mean_pkg: sizing helpers shared by the moving-mean filter and its sample store
package mean_pkg;
  function automatic int clog2(input int n);
    int r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
  function automatic int sum_w(input int dw, input int l2w);
    return dw + l2w;
  endfunction
endpackage

// File: rtl/mean_sample_ram.sv
// mean_sample_ram: per-channel sample history, read-first with a registered read port
module mean_sample_ram #(
  parameter int DW = 16,
  parameter int AW = 7,
  parameter int DEPTH = 128
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [DEPTH];
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_o <= mem_q[addr_i];
  end
endmodule

// File: rtl/multi_channel_moving_mean.sv
// multi_channel_moving_mean: per-channel running-sum mean over the last 2**LOG2_WIN samples.
// Define MEAN_ROUND_EN to round half toward +inf instead of flooring.
module multi_channel_moving_mean
  import mean_pkg::*;
#(
  parameter int DW = 16,
  parameter int NUM_CH = 16,
  parameter int LOG2_WIN = 3,
  localparam int CH_W = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH)
) (
  input  logic            CLK,
  input  logic            RESET_n,
  input  logic            CLEAR,
  input  logic            IN_VALID,
  input  logic [CH_W-1:0] IN_CH,
  input  logic [DW-1:0]   IN_DATA,
  output logic            OUT_VALID,
  output logic [CH_W-1:0] OUT_CH,
  output logic [DW-1:0]   OUT_DATA,
  output logic            OUT_FULL
);
  localparam int SUM_W = sum_w(DW, LOG2_WIN);
  localparam int WIN = 2 ** LOG2_WIN;
  typedef struct packed {
    logic            valid;
    logic [CH_W-1:0] ch;
    logic [DW-1:0]   data;
    logic            was_full;
    logic            full;
  } s1_t;
  s1_t s1_q, s1_d;
  logic signed [SUM_W-1:0] sum_q [NUM_CH];
  logic [LOG2_WIN-1:0] wptr_q [NUM_CH];
  logic [LOG2_WIN:0] fill_q [NUM_CH];
  logic [DW-1:0] ram_rd;
  logic accept;
  logic signed [DW-1:0] old;
  logic signed [SUM_W-1:0] sum_new, sum_rnd;
  logic out_valid_q, out_full_q;
  logic [CH_W-1:0] out_ch_q;
  logic [DW-1:0] out_data_q;
  assign accept = IN_VALID && !CLEAR && ({1'b0, IN_CH} < (CH_W + 1)'(NUM_CH));
  // fill saturates at WIN, so its MSB alone marks a full window
  assign s1_d = '{valid: accept, ch: IN_CH, data: IN_DATA,
                  was_full: fill_q[IN_CH][LOG2_WIN],
                  full: fill_q[IN_CH] >= (LOG2_WIN + 1)'(WIN - 1)};
  mean_sample_ram #(.DW(DW), .AW(CH_W + LOG2_WIN), .DEPTH(NUM_CH * WIN)) u_ram (
    .clk_i  (CLK),
    .we_i   (accept),
    .addr_i ({IN_CH, wptr_q[IN_CH]}),
    .wdata_i(IN_DATA),
    .rdata_o(ram_rd)
  );
  // sum_q is written at the end of stage 2, so a back-to-back sample already sees it
  assign old = s1_q.was_full ? signed'(ram_rd) : '0;
  assign sum_new = sum_q[s1_q.ch] - SUM_W'(old) + SUM_W'(signed'(s1_q.data));
`ifdef MEAN_ROUND_EN
  assign sum_rnd = sum_new + SUM_W'(2 ** (LOG2_WIN - 1));
`else
  assign sum_rnd = sum_new;
`endif
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        sum_q[i] <= '0;
        wptr_q[i] <= '0;
        fill_q[i] <= '0;
      end
      s1_q <= '0;
      out_valid_q <= 1'b0;
      out_ch_q <= '0;
      out_data_q <= '0;
      out_full_q <= 1'b0;
    end else if (CLEAR) begin
      for (int i = 0; i < NUM_CH; i++) begin
        sum_q[i] <= '0;
        wptr_q[i] <= '0;
        fill_q[i] <= '0;
      end
      s1_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      out_valid_q <= s1_q.valid;
      if (accept) begin
        wptr_q[IN_CH] <= wptr_q[IN_CH] + LOG2_WIN'(1);
        if (!fill_q[IN_CH][LOG2_WIN]) fill_q[IN_CH] <= fill_q[IN_CH] + (LOG2_WIN + 1)'(1);
      end
      if (s1_q.valid) begin
        sum_q[s1_q.ch] <= sum_new;
        out_ch_q <= s1_q.ch;
        out_data_q <= DW'(sum_rnd >>> LOG2_WIN);
        out_full_q <= s1_q.full;
      end
    end
  end
  assign OUT_VALID = out_valid_q;
  assign OUT_CH = out_ch_q;
  assign OUT_DATA = out_data_q;
  assign OUT_FULL = out_full_q;
endmodule

// File: tb/tb_multi_channel_moving_mean.sv
// tb_multi_channel_moving_mean: directed checks of the moving mean, 6 channels, window 8
module tb_multi_channel_moving_mean;
  logic CLK = 1'b0, RESET_n = 1'b0, CLEAR = 1'b0, IN_VALID = 1'b0;
  logic [2:0] IN_CH = '0;
  logic [15:0] IN_DATA = '0;
  logic OUT_VALID, OUT_FULL;
  logic [2:0] OUT_CH;
  logic [15:0] OUT_DATA;
  int checks = 0, errors = 0;
`ifdef MEAN_ROUND_EN
  localparam int RND = 4;
`else
  localparam int RND = 0;
`endif
  int sums4 [16] = '{0, 1, 3, 6, 10, 15, 21, 28, 36, 44, 52, 60, 68, 76, 84, 92};
  int t5 = (RND != 0) ? 3 : 2;
  multi_channel_moving_mean #(.DW(16), .NUM_CH(6), .LOG2_WIN(3)) dut (
    .CLK(CLK), .RESET_n(RESET_n), .CLEAR(CLEAR), .IN_VALID(IN_VALID), .IN_CH(IN_CH),
    .IN_DATA(IN_DATA), .OUT_VALID(OUT_VALID), .OUT_CH(OUT_CH), .OUT_DATA(OUT_DATA),
    .OUT_FULL(OUT_FULL)
  );
  always #5 CLK = ~CLK;
  function automatic int mn(input int s);
    return (s + RND) >>> 3;
  endfunction
  task automatic step(input logic v, input int ch, input int d);
    IN_VALID = v;
    IN_CH = 3'(ch);
    IN_DATA = 16'(d);
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic v, input int ch, input int d, input logic f);
    checks++;
    assert (OUT_VALID === v && (!v || (OUT_CH === 3'(ch) && OUT_DATA === 16'(d) && OUT_FULL === f)))
    else begin
      errors++;
      $error("FAIL %s: got v=%0b ch=%0d d=%0d f=%0b, want v=%0b ch=%0d d=%0d f=%0b",
             tag, OUT_VALID, OUT_CH, $signed(OUT_DATA), OUT_FULL, v, ch, d, f);
    end
  endtask
  task automatic chk_reset(input string tag);
    checks++;
    assert (OUT_VALID === 1'b0 && OUT_CH === 3'd0 && OUT_DATA === 16'd0 && OUT_FULL === 1'b0)
    else begin
      errors++;
      $error("FAIL %s: got v=%0b ch=%0d d=%0d f=%0b, want all zero",
             tag, OUT_VALID, OUT_CH, $signed(OUT_DATA), OUT_FULL);
    end
  endtask
  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk_reset("reset_state");
    @(negedge CLK);
    RESET_n = 1'b1;
    @(posedge CLK);
    #1;
    // ramp-up of ch0 with 100s, then replace the window with -100s
    for (int k = 0; k < 8; k++) begin
      step(1, 0, 100);
      if (k > 0) chk("t1_ramp", 1, 0, mn(100 * k), 1'b0);
    end
    for (int k = 0; k < 8; k++) begin
      step(1, 0, -100);
      if (k == 0) chk("t1_last", 1, 0, mn(800), 1'b1);
      else chk("t2_down", 1, 0, mn(800 - 200 * k), 1'b1);
    end
    step(0, 0, 0);
    chk("t2_last", 1, 0, -100, 1'b1);
    CLEAR = 1'b1;
    step(0, 0, 0);
    CLEAR = 1'b0;
    chk("clear_idle", 0, 0, 0, 1'b0);
    // interleaved channels must not disturb each other
    for (int i = 0; i < 16; i++) begin
      step(1, (i % 2) ? 5 : 0, (i % 2) ? -1000 : 1000);
      if (i > 0) chk("t3_inter", 1, ((i - 1) % 2) ? 5 : 0,
                     (((i - 1) % 2) ? -125 : 125) * ((i - 1) / 2 + 1), ((i - 1) / 2) == 7);
    end
    step(0, 0, 0);
    chk("t3_last", 1, 5, -1000, 1'b1);
    CLEAR = 1'b1;
    step(0, 0, 0);
    CLEAR = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step(1, 0, k);
      if (k > 0) chk("t4_burst", 1, 0, mn(sums4[k - 1]), (k - 1) >= 7);
    end
    step(0, 0, 0);
    chk("t4_burst_last", 1, 0, mn(sums4[15]), 1'b1);
    CLEAR = 1'b1;
    step(0, 0, 0);
    CLEAR = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step(1, 0, k);
      step(0, 0, 0);
      chk("t4_gapped", 1, 0, mn(sums4[k]), k >= 7);
    end
    CLEAR = 1'b1;
    step(0, 0, 0);
    CLEAR = 1'b0;
    step(1, 0, 3); step(1, 0, 3); step(1, 0, 2); step(1, 0, 2);
    step(1, 0, 3); step(1, 0, 3); step(1, 0, 2); step(1, 0, 2);
    step(0, 0, 0);
    chk("t5_round", 1, 0, t5, 1'b1);
    step(1, 6, 500);
    step(1, 7, 500);
    chk("drop_ch6", 0, 0, 0, 1'b0);
    step(0, 0, 0);
    chk("drop_ch7", 0, 0, 0, 1'b0);
    // CLEAR squashes the sample in stage 2 and ignores the one offered with it
    step(1, 0, 50);
    CLEAR = 1'b1;
    step(1, 0, 70);
    CLEAR = 1'b0;
    chk("t6_squash", 0, 0, 0, 1'b0);
    step(0, 0, 0);
    chk("t6_ignored", 0, 0, 0, 1'b0);
    step(1, 0, 80);
    step(0, 0, 0);
    chk("t6_after_clear", 1, 0, 10, 1'b0);
    for (int k = 0; k < 7; k++) step(1, 0, 80);
    step(1, 0, 80);
    step(1, 0, 80);
    chk("t6_full_80", 1, 0, 80, 1'b1);
    RESET_n = 1'b0;
    #1;
    chk_reset("t6_async_reset");
    IN_VALID = 1'b0;
    @(negedge CLK);
    RESET_n = 1'b1;
    @(posedge CLK);
    #1;
    step(1, 0, 80);
    step(0, 0, 0);
    chk("t6_after_reset", 1, 0, 10, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
